// File: rtl/divider.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Shares the trigger/ready/done handshake with the multiplier; optional fixed-point scaling.
module divider #(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 0
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    output logic [C_WIDTH-1:0] y,
    output logic [C_WIDTH-1:0] r,
    output logic               ready,
    output logic               done,
    output logic               div_zero,
    output logic               overflow
);

    localparam int N     = C_WIDTH + FIXED_POINT;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       dvd_q, dvd_d;
    logic [C_WIDTH:0]   rem_q, rem_d;
    logic [C_WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_WIDTH-1:0] y_q, y_d;
    logic [C_WIDTH-1:0] r_q, r_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic               overflow_q, overflow_d;

    logic [C_WIDTH+1:0] rem_shift;
    logic [C_WIDTH+1:0] dvs_ext;
    logic [C_WIDTH+1:0] rem_trial;
    logic               q_bit;
    logic [C_WIDTH:0]   rem_next;
    logic [N-1:0]       quo_next;
    logic [N-1:0]       a_ext;
    logic               accept;

    // The dividend register doubles as the quotient register: quotient bits enter at the LSB
    // as dividend bits leave at the MSB, so after N steps it holds the full N-bit quotient.
    always_comb begin
        rem_shift = {rem_q, dvd_q[N-1]};
        dvs_ext   = {2'b00, dvs_q};
        q_bit     = (rem_shift >= dvs_ext);
        rem_trial = q_bit ? (rem_shift - dvs_ext) : rem_shift;
        rem_next  = (C_WIDTH + 1)'(rem_trial);
        quo_next  = {dvd_q[N-2:0], q_bit};
        a_ext     = N'(a) << FIXED_POINT;
        accept    = ready_q & trigger;
    end

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        r_d        = r_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    dvd_d = a_ext;
                    dvs_d = b;
                    rem_d = '0;
                    cnt_d = CNT_W'(N);
                    if (b == '0) begin
                        state_d    = DONE;
                        y_d        = '1;
                        r_d        = a;
                        div_zero_d = 1'b1;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = DONE;
                    y_d        = C_WIDTH'(quo_next);
                    r_d        = C_WIDTH'(rem_next);
                    div_zero_d = 1'b0;
                    overflow_d = |(quo_next >> C_WIDTH);
                end
            end
            default: state_d = IDLE;
        endcase

        // ready/done are registered from the next state so they line up with it exactly.
        ready_d = (state_d != BUSY);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            y_q        <= '0;
            r_q        <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            r_q        <= r_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign y        = y_q;
    assign r        = r_q;
    assign ready    = ready_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: integer instance and 16-bit fixed-point instance,
// hand-derived vector table, multi-cycle corner sequences and a random arithmetic model.
module tb_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trig0, trig1;
    logic [31:0] a_in, b_in;
    logic [31:0] y0, r0, y1, r1;
    logic        ready0, done0, dz0, ovf0;
    logic        ready1, done1, dz1, ovf1;

    logic        sel;
    logic [31:0] cur_y, cur_r;
    logic        cur_ready, cur_done, cur_dz, cur_ovf;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        string       name;
        bit          fp;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    divider #(.C_WIDTH(32), .FIXED_POINT(0)) dut (
        .ctl_clk(clk), .reset(reset_n), .trigger(trig0), .a(a_in), .b(b_in),
        .y(y0), .r(r0), .ready(ready0), .done(done0), .div_zero(dz0), .overflow(ovf0)
    );

    divider #(.C_WIDTH(32), .FIXED_POINT(16)) dut_fp (
        .ctl_clk(clk), .reset(reset_n), .trigger(trig1), .a(a_in), .b(b_in),
        .y(y1), .r(r1), .ready(ready1), .done(done1), .div_zero(dz1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    always_comb begin
        cur_y     = sel ? y1 : y0;
        cur_r     = sel ? r1 : r0;
        cur_ready = sel ? ready1 : ready0;
        cur_done  = sel ? done1 : done0;
        cur_dz    = sel ? dz1 : dz0;
        cur_ovf   = sel ? ovf1 : ovf0;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic set_trig(input bit s, input logic v);
        if (s) trig1 = v;
        else   trig0 = v;
    endtask

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!cur_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Arithmetic reference: quotient of the scaled dividend, saturating rules for b == 0.
    function automatic void ref_model(input bit fp, input logic [31:0] av, input logic [31:0] bv,
                                      output logic [31:0] ey, output logic [31:0] er,
                                      output logic edz, output logic eov, output int elat);
        longint unsigned num, q;
        int shift = fp ? 16 : 0;
        if (bv == 32'd0) begin
            ey = 32'hFFFF_FFFF; er = av; edz = 1'b1; eov = 1'b0; elat = 1;
        end else begin
            num  = {32'd0, av} << shift;
            q    = num / {32'd0, bv};
            ey   = q[31:0];
            er   = 32'(num % {32'd0, bv});
            edz  = 1'b0;
            eov  = (q >> 32) != 0;
            elat = 32 + shift + 1;
        end
    endfunction

    task automatic applyStimulus(input bit s, input logic [31:0] av, input logic [31:0] bv,
                                 output int lat, output bit busy_ready_bad);
        sel = s;
        wait_ready();
        a_in = av;
        b_in = bv;
        set_trig(s, 1'b1);
        @(posedge clk);
        #1;
        set_trig(s, 1'b0);
        a_in = $urandom;
        b_in = $urandom;
        lat = 0;
        busy_ready_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!cur_done && cur_ready) busy_ready_bad = 1'b1;
        end while (!cur_done && lat < 200);
    endtask

    task automatic run_vector(input string name, input bit s, input logic [31:0] av,
                              input logic [31:0] bv, input logic [31:0] ey, input logic [31:0] er,
                              input logic edz, input logic eov, input int elat);
        int lat;
        bit bad;
        applyStimulus(s, av, bv, lat, bad);
        checkOutput({name, "_lat"}, lat, elat);
        checkOutput({name, "_y"}, cur_y, ey);
        checkOutput({name, "_r"}, cur_r, er);
        checkOutput({name, "_dz"}, cur_dz, edz);
        checkOutput({name, "_ovf"}, cur_ovf, eov);
        checkOutput({name, "_busy_ready"}, bad, 0);
        @(negedge clk);
        checkOutput({name, "_done_once"}, cur_done, 0);
    endtask

    initial begin
        int          lat;
        bit          saw_done;
        logic [31:0] ey, er, av, bv;
        logic        edz, eov;
        int          elat;
        bit          fp;

        vecs[0]  = '{"basic",     0, 32'h64,        32'h7,        32'hE,        32'h2,    0, 0, 33};
        vecs[1]  = '{"divzero",   0, 32'h1234,      32'h0,        32'hFFFFFFFF, 32'h1234, 1, 0, 1};
        vecs[2]  = '{"fp_1p5",    1, 32'h00030000,  32'h00020000, 32'h00018000, 32'h0,    0, 0, 49};
        vecs[3]  = '{"fp_ovf",    1, 32'hFFFF0000,  32'h1,        32'h0,        32'h0,    0, 1, 49};
        vecs[4]  = '{"small",     0, 32'h303,       32'h505,      32'h0,        32'h303,  0, 0, 33};
        vecs[5]  = '{"big",       0, 32'hFEDCBA98,  32'h12345678, 32'hE,        32'h8,    0, 0, 33};
        vecs[6]  = '{"fp_divzero",1, 32'h5,         32'h0,        32'hFFFFFFFF, 32'h5,    1, 0, 1};
        vecs[7]  = '{"zero_num",  0, 32'h0,         32'h5,        32'h0,        32'h0,    0, 0, 33};
        vecs[8]  = '{"lt_div",    0, 32'h7,         32'h9,        32'h0,        32'h7,    0, 0, 33};
        vecs[9]  = '{"fp_third",  1, 32'h1,         32'h3,        32'h5555,     32'h1,    0, 0, 49};
        vecs[10] = '{"max_by_1",  0, 32'hFFFFFFFF,  32'h1,        32'hFFFFFFFF, 32'h0,    0, 0, 33};

        sel     = 1'b0;
        trig0   = 1'b0;
        trig1   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        reset_n = 1'b0;

        #10;
        checkOutput("reset_outputs",
                    {y0, r0, ready0, done0, dz0, ovf0, y1[15:0], r1[15:0], ready1, done1, dz1, ovf1},
                    '0);
        #7;
        reset_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", {ready0, ready1}, 2'b00);
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", {ready0, ready1, done0, done1}, 4'b1100);

        foreach (vecs[i])
            run_vector(vecs[i].name, vecs[i].fp, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].r,
                       vecs[i].dz, vecs[i].ovf, vecs[i].lat);

        // Back-to-back: trigger held through done, operands switched in the done cycle.
        sel = 1'b0;
        wait_ready();
        a_in  = 32'h303;
        b_in  = 32'h505;
        trig0 = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done0 && lat < 200);
        checkOutput("b2b_first_lat", lat, 33);
        checkOutput("b2b_first_y", y0, 32'h0);
        checkOutput("b2b_first_r", r0, 32'h303);
        a_in = 32'hFEDCBA98;
        b_in = 32'h12345678;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done0 && lat < 200);
        trig0 = 1'b0;
        checkOutput("b2b_second_lat", lat, 33);
        checkOutput("b2b_second_y", y0, 32'hE);
        checkOutput("b2b_second_r", r0, 32'h8);
        @(negedge clk);
        checkOutput("b2b_done_drop", done0, 0);

        // Trigger pulsed mid-operation is ignored; previous result holds while busy.
        run_vector("pre_ignore", 0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 0, 0, 33);
        wait_ready();
        a_in  = 32'd1000;
        b_in  = 32'd3;
        trig0 = 1'b1;
        @(posedge clk);
        #1;
        trig0 = 1'b0;
        lat = 0;
        repeat (5) begin @(negedge clk); lat++; end
        checkOutput("hold_during_busy", y0, 32'hFFFFFFFF);
        a_in  = 32'd7;
        b_in  = 32'd1;
        trig0 = 1'b1;
        @(negedge clk);
        lat++;
        trig0 = 1'b0;
        while (!done0 && lat < 200) begin @(negedge clk); lat++; end
        checkOutput("ignored_trig_lat", lat, 33);
        checkOutput("ignored_trig_y", y0, 32'd333);
        checkOutput("ignored_trig_r", r0, 32'd1);
        @(negedge clk);
        checkOutput("ignored_trig_no_restart", {done0, ready0}, 2'b01);

        // Reset at iteration 10 aborts the operation without a done pulse.
        wait_ready();
        a_in  = 32'h64;
        b_in  = 32'h7;
        trig0 = 1'b1;
        @(posedge clk);
        #1;
        trig0 = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin @(negedge clk); if (done0) saw_done = 1'b1; end
        reset_n = 1'b0;
        #1;
        checkOutput("abort_outputs", {y0, r0, ready0, done0, dz0, ovf0}, '0);
        repeat (3) begin @(negedge clk); if (done0) saw_done = 1'b1; end
        reset_n = 1'b1;
        repeat (40) begin @(negedge clk); if (done0) saw_done = 1'b1; end
        checkOutput("abort_no_done", saw_done, 0);
        run_vector("after_abort", 0, 32'h64, 32'h7, 32'hE, 32'h2, 0, 0, 33);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            fp = (i % 3) == 0;
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = $urandom_range(1, 15);
                1:       bv = $urandom;
                2:       bv = av >> $urandom_range(0, 12);
                default: bv = $urandom & 32'h0000FFFF;
            endcase
            ref_model(fp, av, bv, ey, er, edz, eov, elat);
            run_vector($sformatf("rand%0d", i), fp, av, bv, ey, er, edz, eov, elat);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
